// File: rtl/sad_pe_acc.sv
// Windowed sum-of-absolute-differences processing element with a saturating accumulator.
// Optional result saturation flag output res_sat, enabled by defining SAD_SAT_FLAG_EN.
module sad_pe_acc #(
    parameter int DATA_W    = 8,
    parameter int WIN_LEN   = 16,
    parameter int ACC_W     = 12,
    parameter int THRESHOLD = 500
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_t,
    input  logic [DATA_W-1:0] in_i,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_sad
`ifdef SAD_SAT_FLAG_EN
    ,
    output logic              res_sat
`endif
);

    localparam int SUM_W = ACC_W + 1;
    localparam int CNT_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);
    localparam logic [SUM_W-1:0] THRESH_X = SUM_W'(THRESHOLD);

    typedef enum logic {ST_ACC, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   res_sad_q, res_sad_d;
    logic [DATA_W-1:0]  diff;
    logic [SUM_W-1:0]   sum;
    logic [ACC_W-1:0]   sum_clamped;
    logic               accept;
    logic               win_last;
`ifdef SAD_SAT_FLAG_EN
    logic               sat_seen_q, sat_seen_d;
    logic               res_sat_q, res_sat_d;
    logic               sum_hit;
`endif

    function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [ACC_W-1:0] clamp_sum(input logic [SUM_W-1:0] s);
        return (s < THRESH_X) ? s[ACC_W-1:0] : THRESH_X[ACC_W-1:0];
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACC;
        end else begin
            state_q <= state_d;
        end
    end

    assign accept   = in_valid && (state_q == ST_ACC);
    assign win_last = accept && (cnt_q == CNT_LAST);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACC:  if (win_last) state_d = ST_DONE;
            ST_DONE: if (res_ready) state_d = ST_ACC;
            default: state_d = ST_ACC;
        endcase
    end

    // Output decode: both handshakes depend on state only
    always_comb begin
        in_ready  = (state_q == ST_ACC);
        res_valid = (state_q == ST_DONE);
    end

    // Datapath: sum is one bit wider than acc so the clamp compare never wraps
    always_comb begin
        diff        = abs_diff(in_t, in_i);
        sum         = SUM_W'(acc_q) + SUM_W'(diff);
        sum_clamped = clamp_sum(sum);
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        res_sad_d   = res_sad_q;
`ifdef SAD_SAT_FLAG_EN
        sum_hit     = (sum >= THRESH_X);
        sat_seen_d  = sat_seen_q;
        res_sat_d   = res_sat_q;
`endif
        if (accept) begin
            acc_d = sum_clamped;
            cnt_d = win_last ? '0 : cnt_q + CNT_W'(1);
`ifdef SAD_SAT_FLAG_EN
            sat_seen_d = win_last ? 1'b0 : (sat_seen_q | sum_hit);
`endif
        end
        if (win_last) begin
            res_sad_d = sum_clamped;
`ifdef SAD_SAT_FLAG_EN
            res_sat_d = sat_seen_q | sum_hit;
`endif
        end
        if ((state_q == ST_DONE) && res_ready) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            res_sad_q  <= '0;
`ifdef SAD_SAT_FLAG_EN
            sat_seen_q <= 1'b0;
            res_sat_q  <= 1'b0;
`endif
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            res_sad_q  <= res_sad_d;
`ifdef SAD_SAT_FLAG_EN
            sat_seen_q <= sat_seen_d;
            res_sat_q  <= res_sat_d;
`endif
        end
    end

    assign res_sad = res_sad_q;
`ifdef SAD_SAT_FLAG_EN
    assign res_sat = res_sat_q;
`endif

endmodule

// File: tb/tb_sad_pe_acc.sv
// Directed and randomized bench for sad_pe_acc against a window-level reference model.
// res_sat checks are active when SAD_SAT_FLAG_EN is defined.
module tb_sad_pe_acc;

    localparam int DATA_W    = 8;
    localparam int WIN_LEN   = 16;
    localparam int ACC_W     = 12;
    localparam int THRESHOLD = 500;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              in_valid  = 1'b0;
    logic              res_ready = 1'b1;
    logic [DATA_W-1:0] in_t      = '0;
    logic [DATA_W-1:0] in_i      = '0;
    logic              in_ready;
    logic              res_valid;
    logic [ACC_W-1:0]  res_sad;
`ifdef SAD_SAT_FLAG_EN
    logic              res_sat;
`endif

    sad_pe_acc #(
        .DATA_W(DATA_W), .WIN_LEN(WIN_LEN), .ACC_W(ACC_W), .THRESHOLD(THRESHOLD)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_t(in_t), .in_i(in_i),
        .res_valid(res_valid), .res_ready(res_ready), .res_sad(res_sad)
`ifdef SAD_SAT_FLAG_EN
        , .res_sat(res_sat)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: window sum of |t-i| saturating at THRESHOLD
    int m_acc = 0;
    int m_cnt = 0;
    int exp_sad_q[$];
`ifdef SAD_SAT_FLAG_EN
    int m_sat = 0;
    int exp_sat_q[$];
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_acc = 0;
        m_cnt = 0;
`ifdef SAD_SAT_FLAG_EN
        m_sat = 0;
`endif
    endtask

    task automatic model_accept(input int t, input int i);
        int d;
        int s;
        d = (t > i) ? t - i : i - t;
        s = m_acc + d;
`ifdef SAD_SAT_FLAG_EN
        if (s >= THRESHOLD) m_sat = 1;
`endif
        m_acc = (s < THRESHOLD) ? s : THRESHOLD;
        m_cnt++;
        if (m_cnt == WIN_LEN) begin
            exp_sad_q.push_back(m_acc);
`ifdef SAD_SAT_FLAG_EN
            exp_sat_q.push_back(m_sat);
`endif
            model_reset();
        end
    endtask

    task automatic send(input int t, input int i, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_t = DATA_W'($urandom);
            in_i = DATA_W'($urandom);
        end
        @(negedge clk);
        n = 0;
        while (in_ready !== 1'b1 && n < 64) begin
            in_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) check("send_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_t = DATA_W'(t);
        in_i = DATA_W'(i);
        model_accept(t, i);
    endtask

    task automatic window(input int t, input int i, input int gap);
        repeat (WIN_LEN) send(t, i, gap);
    endtask

    // Called right after the last accept of a window: checks latency, value, hold and release
    task automatic check_result(input string tag, input int hold);
        int es;
`ifdef SAD_SAT_FLAG_EN
        int et;
`endif
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_valid_latency"}, 32'(res_valid), 32'd1);
        check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
        es = exp_sad_q.pop_front();
        check({tag, "_sad"}, 32'(res_sad), 32'(es));
`ifdef SAD_SAT_FLAG_EN
        et = exp_sat_q.pop_front();
        check({tag, "_sat"}, 32'(res_sat), 32'(et));
`endif
        res_ready = (hold > 0) ? 1'b0 : 1'b1;
        repeat (hold) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
            check({tag, "_hold_sad"}, 32'(res_sad), 32'(es));
`ifdef SAD_SAT_FLAG_EN
            check({tag, "_hold_sat"}, 32'(res_sat), 32'(et));
`endif
        end
        res_ready = 1'b1;
        @(negedge clk);
        check({tag, "_release_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_release_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_sad_kept_in_acc"}, 32'(res_sad), 32'(es));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int i;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_res_valid", 32'(res_valid), 32'd0);
        check("reset_res_sad", 32'(res_sad), 32'd0);
`ifdef SAD_SAT_FLAG_EN
        check("reset_res_sat", 32'(res_sat), 32'd0);
`endif

        window(10, 3, 0);
        check_result("pos_diff", 0);
        window(3, 10, 0);
        check_result("neg_diff", 0);
        window(0, 255, 0);
        check_result("full_sat", 0);

        repeat (4) send(125, 0, 0);
        repeat (12) send(77, 77, 0);
        check_result("exact_boundary", 0);

        window(5, 0, 0);
        check_result("backpressure", 5);
        window(1, 0, 0);
        check_result("after_backpressure", 0);

        window(0, 2, 1);
        check_result("valid_toggle", 0);

        repeat (7) send(50, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset_valid", 32'(res_valid), 32'd0);
        check("mid_reset_in_ready", 32'(in_ready), 32'd1);
        check("mid_reset_sad", 32'(res_sad), 32'd0);
        window(1, 0, 0);
        check_result("after_reset", 0);

        for (int w = 0; w < 6; w++) begin
            for (int k = 0; k < WIN_LEN; k++) begin
                t = int'($urandom_range(0, 255));
                i = (w % 2 == 1) ? int'($urandom_range(0, 255))
                                 : (t + int'($urandom_range(0, 40))) % 256;
                res_ready = 1'($urandom);
                send(t, i, int'($urandom_range(0, 2)));
            end
            check_result("random", int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
